// File: rtl/gen_arb_pkg.sv
// gen_arb_pkg: shared encodings and the winner-selection function for the
// N-port request/acknowledge arbiter.
package gen_arb_pkg;

   localparam int MAX_PORTS = 8;

   typedef enum logic [1:0] {
      DEV_IDLE = 2'd0,
      DEV_REQ  = 2'd1,
      DEV_ACK  = 2'd2,
      DEV_DONE = 2'd3
   } dev_state_e;

   typedef enum logic [1:0] {
      PORT_IDLE    = 2'd0,
      PORT_PEND    = 2'd1,
      PORT_WAITLOW = 2'd2
   } port_state_e;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } pick_t;

   // Round-robin scans upward from last+1 with wrap at nport; fixed
   // priority scans upward from port 0. The first pending port wins.
   function automatic pick_t rr_pick(input logic [7:0] pending,
                                     input logic [2:0] last,
                                     input int         nport,
                                     input bit         rr);
      pick_t      res;
      int         cand;
      logic [7:0] shifted;
      res = '0;
      for (int k = 0; k < MAX_PORTS; k++) begin
         if (k < nport) begin
            cand = rr ? (int'(last) + 1 + k) : k;
            if (cand >= nport) begin
               cand = cand - nport;
            end
            shifted = pending >> cand;
            if (!res.valid && shifted[0]) begin
               res.valid = 1'b1;
               res.idx   = 3'(cand);
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/gen_arb_lane.sv
// gen_arb_lane: steers device read data onto a 32-bit master read bus,
// either as a replicated byte for 8-bit ports or as native-width data.
module gen_arb_lane
   import gen_arb_pkg::*;
#(
   parameter int DEV_WIDTH = 16
) (
   input  logic        is8,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   localparam bit WIDE = (DEV_WIDTH == 32);

   logic [1:0] byte_sel;
   logic [7:0] lane_byte;

   // Big-endian byte pick; a 16-bit device only drives the low halfword, so
   // its two byte lanes map onto the lower two positions of the 32-bit view.
   always_comb begin
      byte_sel = WIDE ? addr_lo : {1'b1, addr_lo[0]};
      case (byte_sel)
         2'd0:    lane_byte = rdata[31:24];
         2'd1:    lane_byte = rdata[23:16];
         2'd2:    lane_byte = rdata[15:8];
         default: lane_byte = rdata[7:0];
      endcase
      if (is8) begin
         result = {4{lane_byte}};
      end else if (WIDE) begin
         result = rdata;
      end else begin
         result = {2{rdata[15:0]}};
      end
   end

endmodule

// File: rtl/gen_arb_rr.sv
// gen_arb_rr: N-port request/acknowledge arbiter onto one device port,
// with round-robin or fixed-priority selection and per-port read steering.
module gen_arb_rr
   import gen_arb_pkg::*;
#(
   parameter int         NPORT     = 4,
   parameter int         DEV_WIDTH = 16,
   parameter logic [7:0] P8_MASK   = 8'h00,
   parameter int         RR        = 1
) (
   input  logic                  dev_clk,
   input  logic                  dev_rst_n,
   input  logic [NPORT*32-1:0]   p_addr,
   input  logic [NPORT*32-1:0]   p_wdata,
   input  logic [NPORT*4-1:0]    p_be,
   input  logic [NPORT-1:0]      p_wr,
   input  logic [NPORT-1:0]      p_req,
   output logic [NPORT*32-1:0]   p_rdata,
   output logic [NPORT-1:0]      p_ack,
   output logic [31:0]           dev_addr,
   output logic [31:0]           dev_wdata,
   output logic [3:0]            dev_be,
   output logic                  dev_wr,
   output logic                  dev_req,
   input  logic [31:0]           dev_rdata,
   input  logic                  dev_ack,
   output logic [2:0]            grant,
   output logic                  busy
);

   localparam logic [2:0] GRANT_RST = 3'(NPORT - 1);

   dev_state_e  state_q, state_d;
   port_state_e port_q [NPORT];
   port_state_e port_d [NPORT];

   logic [2:0]       grant_q, grant_d;
   logic [31:0]      dev_addr_q, dev_addr_d;
   logic [31:0]      dev_wdata_q, dev_wdata_d;
   logic [3:0]       dev_be_q, dev_be_d;
   logic             dev_wr_q, dev_wr_d;
   logic             dev_req_q, dev_req_d;
   logic [31:0]      cap_q, cap_d;
   logic [NPORT-1:0] p_ack_q, p_ack_d;
   logic [31:0]      p_rdata_q [NPORT];
   logic [31:0]      p_rdata_d [NPORT];
   logic [31:0]      lane_out  [NPORT];

   logic [31:0] addr_arr  [MAX_PORTS];
   logic [31:0] wdata_arr [MAX_PORTS];
   logic [3:0]  be_arr    [MAX_PORTS];
   logic [7:0]  wr_vec;
   logic [7:0]  pend_vec;
   pick_t       pick;

   // Unpack the flat port buses into fixed 8-entry tables and choose a winner.
   always_comb begin
      wr_vec   = '0;
      pend_vec = '0;
      for (int k = 0; k < MAX_PORTS; k++) begin
         addr_arr[k]  = '0;
         wdata_arr[k] = '0;
         be_arr[k]    = '0;
      end
      for (int i = 0; i < NPORT; i++) begin
         addr_arr[i]  = p_addr[32*i +: 32];
         wdata_arr[i] = p_wdata[32*i +: 32];
         be_arr[i]    = p_be[4*i +: 4];
         wr_vec[i]    = p_wr[i];
         pend_vec[i]  = (port_q[i] == PORT_PEND);
      end
      pick = rr_pick(pend_vec, grant_q, NPORT, RR != 0);
   end

   // Port front ends: one access per request, master must drop req to re-arm.
   always_comb begin
      for (int i = 0; i < NPORT; i++) begin
         port_d[i] = port_q[i];
         case (port_q[i])
            PORT_IDLE:    if (p_req[i]) port_d[i] = PORT_PEND;
            PORT_PEND:    if (state_q == DEV_ACK && grant_q == 3'(i)) port_d[i] = PORT_WAITLOW;
            PORT_WAITLOW: if (!p_req[i]) port_d[i] = PORT_IDLE;
            default:      port_d[i] = PORT_IDLE;
         endcase
      end
   end

   // Device sequencer: latch the winner, hold the request, capture read data.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      dev_addr_d  = dev_addr_q;
      dev_wdata_d = dev_wdata_q;
      dev_be_d    = dev_be_q;
      dev_wr_d    = dev_wr_q;
      dev_req_d   = dev_req_q;
      cap_d       = cap_q;
      case (state_q)
         DEV_IDLE: begin
            if (pick.valid) begin
               grant_d     = pick.idx;
               dev_addr_d  = addr_arr[pick.idx];
               dev_wdata_d = wdata_arr[pick.idx];
               dev_be_d    = be_arr[pick.idx];
               dev_wr_d    = wr_vec[pick.idx];
               dev_req_d   = 1'b1;
               state_d     = DEV_REQ;
            end
         end
         DEV_REQ: begin
            if (dev_ack) begin
               cap_d     = dev_rdata;
               dev_req_d = 1'b0;
               state_d   = DEV_ACK;
            end
         end
         DEV_ACK:  state_d = DEV_DONE;
         DEV_DONE: state_d = DEV_IDLE;
         default:  state_d = DEV_IDLE;
      endcase
   end

   // Completion: pulse the granted port's ack and load its steered read data.
   always_comb begin
      for (int i = 0; i < NPORT; i++) begin
         p_ack_d[i]   = (state_q == DEV_ACK) && (grant_q == 3'(i));
         p_rdata_d[i] = p_ack_d[i] ? lane_out[i] : p_rdata_q[i];
      end
   end

   for (genvar g = 0; g < NPORT; g++) begin : g_lane
      gen_arb_lane #(
         .DEV_WIDTH (DEV_WIDTH)
      ) u_lane (
         .is8     (P8_MASK[g]),
         .addr_lo (dev_addr_q[1:0]),
         .rdata   (cap_q),
         .result  (lane_out[g])
      );
   end

   // State registers; reset aborts any access in flight without acking it.
   always_ff @(posedge dev_clk or negedge dev_rst_n) begin
      if (!dev_rst_n) begin
         state_q     <= DEV_IDLE;
         grant_q     <= GRANT_RST;
         dev_addr_q  <= '0;
         dev_wdata_q <= '0;
         dev_be_q    <= '0;
         dev_wr_q    <= 1'b0;
         dev_req_q   <= 1'b0;
         cap_q       <= '0;
         p_ack_q     <= '0;
         for (int i = 0; i < NPORT; i++) begin
            port_q[i]    <= PORT_IDLE;
            p_rdata_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         dev_addr_q  <= dev_addr_d;
         dev_wdata_q <= dev_wdata_d;
         dev_be_q    <= dev_be_d;
         dev_wr_q    <= dev_wr_d;
         dev_req_q   <= dev_req_d;
         cap_q       <= cap_d;
         p_ack_q     <= p_ack_d;
         for (int i = 0; i < NPORT; i++) begin
            port_q[i]    <= port_d[i];
            p_rdata_q[i] <= p_rdata_d[i];
         end
      end
   end

   // Repack the per-port read registers onto the flat output bus.
   always_comb begin
      for (int i = 0; i < NPORT; i++) begin
         p_rdata[32*i +: 32] = p_rdata_q[i];
      end
   end

   assign p_ack     = p_ack_q;
   assign dev_addr  = dev_addr_q;
   assign dev_wdata = dev_wdata_q;
   assign dev_be    = dev_be_q;
   assign dev_wr    = dev_wr_q;
   assign dev_req   = dev_req_q;
   assign grant     = grant_q;
   assign busy      = (state_q != DEV_IDLE);

endmodule

// File: tb/tb_gen_arb_rr.sv
// tb_gen_arb_rr: directed bench for gen_arb_rr. Two instances share all port
// and device inputs: u_dut (16-bit device, round-robin) and u_dut32 (32-bit
// device, fixed priority); port 0 is an 8-bit port in both.
module tb_gen_arb_rr;

   logic dev_clk   = 1'b0;
   logic dev_rst_n = 1'b1;
   always #5 dev_clk = ~dev_clk;

   logic [127:0] p_addr  = '0;
   logic [127:0] p_wdata = '0;
   logic [15:0]  p_be    = '0;
   logic [3:0]   p_wr    = '0;
   logic [3:0]   p_req   = '0;
   logic [31:0]  dev_rdata = '0;
   logic         dev_ack   = 1'b0;

   logic [127:0] p_rdata_a, p_rdata_b;
   logic [3:0]   p_ack_a, p_ack_b;
   logic [31:0]  dev_addr_a, dev_addr_b, dev_wdata_a, dev_wdata_b;
   logic [3:0]   dev_be_a, dev_be_b;
   logic         dev_wr_a, dev_wr_b, dev_req_a, dev_req_b, busy_a, busy_b;
   logic [2:0]   grant_a, grant_b;

   gen_arb_rr #(.NPORT(4), .DEV_WIDTH(16), .P8_MASK(8'h01), .RR(1)) u_dut (
      .dev_clk(dev_clk), .dev_rst_n(dev_rst_n),
      .p_addr(p_addr), .p_wdata(p_wdata), .p_be(p_be), .p_wr(p_wr), .p_req(p_req),
      .p_rdata(p_rdata_a), .p_ack(p_ack_a),
      .dev_addr(dev_addr_a), .dev_wdata(dev_wdata_a), .dev_be(dev_be_a), .dev_wr(dev_wr_a),
      .dev_req(dev_req_a), .dev_rdata(dev_rdata), .dev_ack(dev_ack),
      .grant(grant_a), .busy(busy_a));

   gen_arb_rr #(.NPORT(4), .DEV_WIDTH(32), .P8_MASK(8'h01), .RR(0)) u_dut32 (
      .dev_clk(dev_clk), .dev_rst_n(dev_rst_n),
      .p_addr(p_addr), .p_wdata(p_wdata), .p_be(p_be), .p_wr(p_wr), .p_req(p_req),
      .p_rdata(p_rdata_b), .p_ack(p_ack_b),
      .dev_addr(dev_addr_b), .dev_wdata(dev_wdata_b), .dev_be(dev_be_b), .dev_wr(dev_wr_b),
      .dev_req(dev_req_b), .dev_rdata(dev_rdata), .dev_ack(dev_ack),
      .grant(grant_b), .busy(busy_b));

   int tests_run  = 0;
   int tests_fail = 0;
   int dev_lat    = 0;
   int dev_cnt    = 0;
   int access_cnt = 0;
   int ack_total  = 0;

   // Device model: answers dev_req after dev_lat extra cycles with a 1-cycle ack.
   always @(negedge dev_clk) begin
      if (dev_ack) begin
         dev_ack = 1'b0;
         dev_cnt = 0;
      end else if (dev_req_a) begin
         if (dev_cnt >= dev_lat) dev_ack = 1'b1;
         else dev_cnt = dev_cnt + 1;
      end else begin
         dev_cnt = 0;
      end
   end

   // Count completed device handshakes and ack pulses seen on u_dut.
   always @(posedge dev_clk) begin
      if (dev_rst_n && dev_req_a && dev_ack) access_cnt = access_cnt + 1;
   end
   always @(posedge dev_clk) begin
      #1;
      ack_total = ack_total + $countones(p_ack_a);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run = tests_run + 1;
      if (act !== exp) begin
         tests_fail = tests_fail + 1;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      int          port;
      logic [31:0] addr;
      logic [31:0] rdata;
      int          lat;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      int          exp_cyc;
   } vec_t;

   // Single read on one port; returns latency (p_req edge to p_ack), the
   // device address seen, whether u_dut32 acked together, and ack width.
   task automatic applyStimulus(input vec_t v, output int cyc, output logic [31:0] seen_addr,
                                output logic ack_b, output logic ack_after);
      bit got_addr;
      @(negedge dev_clk);
      dev_lat   = v.lat;
      dev_rdata = v.rdata;
      p_addr[32*v.port +: 32] = v.addr;
      p_wr[v.port]  = 1'b0;
      p_req[v.port] = 1'b1;
      cyc = 0; seen_addr = '1; ack_b = 1'b0; got_addr = 1'b0;
      for (int c = 1; c <= 40 && cyc == 0; c++) begin
         @(posedge dev_clk); #1;
         if (dev_req_a && !got_addr) begin
            seen_addr = dev_addr_a;
            got_addr  = 1'b1;
         end
         if (p_ack_a[v.port]) begin
            cyc   = c - 1;
            ack_b = p_ack_b[v.port];
         end
      end
      @(posedge dev_clk); #1;
      ack_after = p_ack_a[v.port] | p_ack_b[v.port];
      p_req[v.port] = 1'b0;
      repeat (2) @(posedge dev_clk);
      #1;
   endtask

   // Raise several requests together and record ack order (one nibble each).
   task automatic runConcurrent(input logic [3:0] mask, input int lat,
                                output logic [15:0] ord_a, output logic [15:0] ord_b);
      int n, got_a, got_b;
      n = $countones(mask);
      got_a = 0; got_b = 0; ord_a = '0; ord_b = '0;
      @(negedge dev_clk);
      dev_lat = lat;
      p_wr  = '0;
      p_req = p_req | mask;
      for (int c = 0; c < 100 && (got_a < n || got_b < n); c++) begin
         @(posedge dev_clk); #1;
         for (int k = 0; k < 4; k++) begin
            if (p_ack_a[k]) begin ord_a = {ord_a[11:0], 4'(k)}; got_a++; p_req[k] = 1'b0; end
            if (p_ack_b[k]) begin ord_b = {ord_b[11:0], 4'(k)}; got_b++; p_req[k] = 1'b0; end
         end
      end
      p_req = p_req & ~mask;
      repeat (3) @(posedge dev_clk);
      #1;
   endtask

   vec_t        vecs [7];
   int          cyc, acc0, ack0, bad, reqcyc;
   logic [31:0] seen_addr;
   logic        ack_b, ack_after, seen;
   logic [15:0] ord_a, ord_b;

   initial begin
      vecs[0] = '{2, 32'h100, 32'h0000ABCD, 1, 32'hABCDABCD, 32'h0000ABCD, 4};
      vecs[1] = '{0, 32'h0,   32'h11221234, 0, 32'h12121212, 32'h11111111, 3};
      vecs[2] = '{0, 32'h1,   32'h11221234, 0, 32'h34343434, 32'h22222222, 3};
      vecs[3] = '{0, 32'h2,   32'h11223344, 0, 32'h33333333, 32'h33333333, 3};
      vecs[4] = '{0, 32'h3,   32'h11223344, 1, 32'h44444444, 32'h44444444, 4};
      vecs[5] = '{1, 32'h4,   32'hCAFEF00D, 2, 32'hF00DF00D, 32'hCAFEF00D, 5};
      vecs[6] = '{3, 32'h10,  32'h89ABCDEF, 0, 32'hCDEFCDEF, 32'h89ABCDEF, 3};

      #1 dev_rst_n = 1'b0;
      #1;
      checkOutput("reset dev_req", 32'(dev_req_a), 32'd0);
      checkOutput("reset busy", 32'(busy_a), 32'd0);
      checkOutput("reset grant_a", 32'(grant_a), 32'd3);
      checkOutput("reset grant_b", 32'(grant_b), 32'd3);
      checkOutput("reset p_ack", 32'(p_ack_a), 32'd0);
      checkOutput("reset p_rdata", p_rdata_a[31:0], 32'd0);
      checkOutput("reset dev_addr", dev_addr_a, 32'd0);
      repeat (2) @(negedge dev_clk);
      dev_rst_n = 1'b1;
      repeat (2) @(posedge dev_clk);

      for (int i = 0; i < 7; i++) begin
         acc0 = access_cnt;
         applyStimulus(vecs[i], cyc, seen_addr, ack_b, ack_after);
         checkOutput($sformatf("v%0d rdata_a", i), p_rdata_a[32*vecs[i].port +: 32], vecs[i].exp_a);
         checkOutput($sformatf("v%0d rdata_b", i), p_rdata_b[32*vecs[i].port +: 32], vecs[i].exp_b);
         checkOutput($sformatf("v%0d latency", i), 32'(cyc), 32'(vecs[i].exp_cyc));
         checkOutput($sformatf("v%0d ack_b", i), 32'(ack_b), 32'd1);
         checkOutput($sformatf("v%0d ack width", i), 32'(ack_after), 32'd0);
         checkOutput($sformatf("v%0d dev_addr", i), seen_addr, vecs[i].addr);
         checkOutput($sformatf("v%0d grant", i), 32'(grant_a), 32'(vecs[i].port));
         checkOutput($sformatf("v%0d accesses", i), 32'(access_cnt - acc0), 32'd1);
      end
      checkOutput("port2 rdata held", p_rdata_a[95:64], 32'hABCDABCD);

      runConcurrent(4'hF, 0, ord_a, ord_b);
      checkOutput("all4 rr order", 32'(ord_a), 32'h0123);
      checkOutput("all4 fixed order", 32'(ord_b), 32'h0123);
      runConcurrent(4'hF, 1, ord_a, ord_b);
      checkOutput("all4 rr order again", 32'(ord_a), 32'h0123);
      checkOutput("all4 fixed order again", 32'(ord_b), 32'h0123);
      runConcurrent(4'b0100, 0, ord_a, ord_b);
      checkOutput("port2 alone", 32'(ord_a), 32'h2);
      runConcurrent(4'b1010, 0, ord_a, ord_b);
      checkOutput("p1p3 rr order", 32'(ord_a), 32'h31);
      checkOutput("p1p3 fixed order", 32'(ord_b), 32'h13);
      runConcurrent(4'b1010, 0, ord_a, ord_b);
      checkOutput("p1p3 rr order again", 32'(ord_a), 32'h31);
      checkOutput("p1p3 fixed order again", 32'(ord_b), 32'h13);

      // Write from port 1 with p_req held for 10 cycles.
      @(negedge dev_clk);
      dev_lat = 2;
      p_addr[63:32]  = 32'h2000;
      p_wdata[63:32] = 32'hDEADBEEF;
      p_be[7:4]      = 4'b0011;
      p_wr[1]  = 1'b1;
      p_req[1] = 1'b1;
      acc0 = access_cnt; ack0 = ack_total; bad = 0; reqcyc = 0;
      repeat (10) begin
         @(posedge dev_clk); #1;
         if (dev_req_a) begin
            reqcyc++;
            if (dev_addr_a !== 32'h2000 || dev_wdata_a !== 32'hDEADBEEF ||
                dev_be_a !== 4'b0011 || dev_wr_a !== 1'b1) bad++;
            if (dev_addr_b !== 32'h2000 || dev_wdata_b !== 32'hDEADBEEF ||
                dev_be_b !== 4'b0011 || dev_wr_b !== 1'b1 || !busy_b) bad++;
         end
      end
      @(negedge dev_clk);
      p_req[1] = 1'b0;
      p_wr[1]  = 1'b0;
      repeat (3) @(posedge dev_clk);
      #1;
      checkOutput("write fields stable", 32'(bad), 32'd0);
      checkOutput("write dev_req cycles", 32'(reqcyc), 32'd3);
      checkOutput("write single access", 32'(access_cnt - acc0), 32'd1);
      checkOutput("write single ack", 32'(ack_total - ack0), 32'd1);
      checkOutput("write grant", 32'(grant_a), 32'd1);

      // Reset while the device is in REQ.
      @(negedge dev_clk);
      dev_lat = 1000;
      p_req[2] = 1'b1;
      ack0 = ack_total;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge dev_clk); #1;
         seen = dev_req_a;
      end
      checkOutput("abort dev_req reached", 32'(seen), 32'd1);
      @(negedge dev_clk);
      #2 dev_rst_n = 1'b0;
      #1;
      checkOutput("abort dev_req low", 32'(dev_req_a), 32'd0);
      checkOutput("abort busy low", 32'(busy_a), 32'd0);
      checkOutput("abort dev_req_b low", 32'(dev_req_b), 32'd0);
      checkOutput("abort grant", 32'(grant_a), 32'd3);
      p_req = '0;
      repeat (3) @(posedge dev_clk);
      @(negedge dev_clk);
      dev_rst_n = 1'b1;
      dev_lat = 0;
      repeat (3) @(posedge dev_clk);
      #1;
      checkOutput("abort no ack", 32'(ack_total - ack0), 32'd0);
      runConcurrent(4'b0101, 0, ord_a, ord_b);
      checkOutput("post-reset rr order", 32'(ord_a), 32'h02);
      checkOutput("post-reset fixed order", 32'(ord_b), 32'h02);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
      $finish;
   end

endmodule

// File: doc/gen_arb_rr.md
# gen_arb_rr

Parametrised N-port request/acknowledge arbiter that multiplexes up to eight masters onto one 16- or 32-bit device port (SDRAM/SRAM controller, register bus). It generalises the team's two-port fixed-priority arbiter: it adds a configurable port count, round-robin or fixed-priority selection, per-port 8-bit read-lane steering, and a grant/status output. It sits between CPU, video and DMA masters and the single device port of the memory controller.

## Interface
- NPORT, 4, number of master ports, 2..8
- DEV_WIDTH, 16, device data width, 16 or 32
- P8_MASK, 0, bit i=1: port i is an 8-bit port (read-lane steering); bit i=0: native width
- RR, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
- dev_clk  in  1  clock
- dev_rst_n  in  1  reset; asynchronous, active-low
- p_addr  in  NPORT*32  per-port address, slice i = [32i+31:32i]
- p_wdata  in  NPORT*32  per-port write data
- p_be  in  NPORT*4  per-port byte enables, passed through unchanged
- p_wr  in  NPORT  1 = write
- p_req  in  NPORT  level request, held until ack
- p_rdata  out  NPORT*32  per-port read data, registered, held between accesses
- p_ack  out  NPORT  one-cycle completion pulse
- dev_addr/dev_wdata  out  32 each  latched from granted port
- dev_be  out  4  latched byte enables
- dev_wr  out  1  latched write flag
- dev_req  out  1  device request, held until dev_ack
- dev_rdata  in  32  device read data, valid with dev_ack
- dev_ack  in  1  device completion
- grant  out  3  index of current/last granted port
- busy  out  1  high in every state except IDLE

## Operation
- Per-port front end: states IDLE→PEND on p_req=1; PEND→WAITLOW when its transaction completes (p_ack pulses); WAITLOW→IDLE once p_req sampled 0. A held p_req never issues a second access; the master must drop req for ≥1 cycle between accesses.
- Device FSM: IDLE, REQ, ACK, DONE.
  - IDLE: if any port is PEND, pick a winner, latch its addr/wdata/be/wr and grant, set dev_req=1 → REQ.
  - REQ: hold dev_req and latched fields; on dev_ack=1, capture dev_rdata, drop dev_req → ACK.
  - ACK: pulse p_ack[grant], load p_rdata[grant] → DONE.
  - DONE: one recovery cycle → IDLE.
- Selection: RR=1 scans from (last grant+1) modulo NPORT upward and takes the first PEND port; RR=0 takes the lowest-index PEND port. The pointer updates only on a grant.
- Read steering, port i in P8_MASK, DEV_WIDTH=16: addr[0]=0 → rdata[15:8]; addr[0]=1 → rdata[7:0]; byte replicated ×4. DEV_WIDTH=32: addr[1:0]=0..3 → rdata[31:24], [23:16], [15:8], [7:0] (big-endian), replicated ×4.
- Read steering, native ports: DEV_WIDTH=16 → {rdata[15:0], rdata[15:0]}; DEV_WIDTH=32 → rdata[31:0].
- p_rdata is also updated on writes (captures whatever dev_rdata holds); masters ignore it for writes.

## Timing
- Reset values: all outputs 0; grant=NPORT-1 (so port 0 wins first under RR); all FSMs in IDLE.
- Edge E0 samples p_req high → PEND. Edge E1 grants (if device IDLE) → dev_req high. With dev_ack at first sample edge E2: ACK state, then p_ack high for the cycle after E3. Minimum p_req-high to p_ack-high is 3 cycles; each extra device wait cycle adds 1.
- Device back-to-back throughput: one grant per 4 cycles plus device wait states.
- Simultaneous requests: all enter PEND on the same edge; order is set by RR/priority; losers stay PEND with no lost requests.
- A port dropping p_req while PEND (protocol violation) is still served; its ack is discarded by the master.
- dev_ack outside REQ is ignored. Asynchronous reset mid-access clears dev_req and pending state immediately; the aborted access is not acked.

## Structure
- Package gen_arb_pkg: device FSM state encoding, port FSM encoding, function rr_pick(pending, last, NPORT, RR).
- Sub-module gen_arb_lane: combinational read-lane steering (DEV_WIDTH, is8, addr[1:0], rdata → 32-bit result), instantiated per port via generate.

## Test plan
- Single read, NPORT=4, port 2 addr 0x100, dev_ack 2 cycles after dev_req, dev_rdata=0x0000ABCD → p_rdata[2]=0xABCDABCD, p_ack[2] 1 cycle wide, p_req→p_ack 4 cycles.
- All four ports request on the same edge, RR=1 → grants 0,1,2,3; re-request all → 0,1,2,3 again; RR=0 with ports 1 and 3 held → 1 served before 3 every round.
- 8-bit port (P8_MASK=4'b0001), DEV_WIDTH=16, rdata=0x1234: addr[0]=0 → 0x12121212; addr[0]=1 → 0x34343434. DEV_WIDTH=32, rdata=0x11223344, addr[1:0]=2 → 0x33333333.
- Write from port 1: addr 0x2000, wdata 0xDEADBEEF, be 4'b0011 → dev_* fields stable for the whole dev_req window, dev_wr=1, exactly one device access while p_req is held 10 cycles.
- Reset asserted while in REQ → dev_req=0 and busy=0 immediately; no p_ack; after release, a new request is served normally from port 0 priority.
